hazard_ctrl: RTL

Pipeline hazard controller that generates the `stall_flag` consumed by the execute stage and a `flush` pulse for the fetch/decode stages. It tracks in-flight register writes through EX/MEM/WB in a 3-slot scoreboard and compares them against the sources of the instruction currently in decode. It holds the pipeline during multi-cycle multiplies and kills wrong-path instructions after a taken branch. Sits between the decode unit (request side) and the execute unit (stall consumer).

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Decode-side request and hazard-response bundle for
//               hazard_ctrl. The master is the decode/EX side and the slave
//               is the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_uses_rt;
    logic [4:0]  id_dest_addr;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_is_mul;
    logic        ex_branch_taken;
    logic        stall_flag;
    logic        flush;
    logic        mul_busy;
    logic [15:0] stall_cycles;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_uses_rt, id_dest_addr,
               id_reg_write, id_mem_read, id_is_mul, ex_branch_taken,
        input  stall_flag, flush, mul_busy, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_uses_rt, id_dest_addr,
               id_reg_write, id_mem_read, id_is_mul, ex_branch_taken,
        output stall_flag, flush, mul_busy, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Tracks in-flight register writes
//               in an EX/MEM/WB scoreboard, raises a combinational stall for
//               RAW hazards and multi-cycle multiplies, and issues a one-cycle
//               registered flush after a taken branch.
//               Optional feature macro: HAZARD_FORWARD_EN (EX/MEM forwarding
//               present, so only load-use in EX stalls).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MUL_LATENCY = 3    // EX cycles occupied by a MUL, 1..15
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    localparam logic [3:0] c_MUL_LOAD  = 4'(MUL_LATENCY - 1);
    localparam logic       c_MUL_MULTI = (MUL_LATENCY > 1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       reg_write;
        logic       is_load;
    } slot_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_mul_cnt;
    logic [3:0]  w_mul_cnt_nxt;
    slot_t       r_ex;
    slot_t       r_mem;
    slot_t       r_wb;
    slot_t       w_issue_slot;
    logic        r_flush;
    logic [15:0] r_stall_cycles;
    logic        w_ex_match;
    logic        w_data_hzd;
    logic        w_stall;
    logic        w_issue;
    logic        w_unused;

    // A producer in a slot is a hazard when it writes a non-zero register
    // that the decode instruction actually reads.
    function automatic logic f_match(input slot_t s, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic urt);
        return s.valid && s.reg_write && (s.dest != 5'd0) &&
               ((s.dest == rs) || (urt && (s.dest == rt)));
    endfunction

    // RAW detection against the scoreboard; WB is never checked because the
    // register file writes before it reads.
`ifdef HAZARD_FORWARD_EN
    always_comb begin
        w_ex_match = f_match(r_ex, bus.id_rs_addr, bus.id_rt_addr, bus.id_uses_rt);
        w_data_hzd = bus.id_valid && w_ex_match && r_ex.is_load;
    end
`else
    logic w_mem_match;
    always_comb begin
        w_ex_match  = f_match(r_ex, bus.id_rs_addr, bus.id_rt_addr, bus.id_uses_rt);
        w_mem_match = f_match(r_mem, bus.id_rs_addr, bus.id_rt_addr, bus.id_uses_rt);
        w_data_hzd  = bus.id_valid && (w_ex_match || w_mem_match);
    end
`endif

    // Stall, issue decision and the slot that enters EX on a RUN edge.
    always_comb begin
        w_stall = (r_state == ST_MUL_BUSY) || (w_data_hzd && !r_flush);
        w_issue = bus.id_valid && !w_stall && !r_flush;
        w_issue_slot = '0;
        if (w_issue) begin
            w_issue_slot.valid     = 1'b1;
            w_issue_slot.dest      = bus.id_dest_addr;
            w_issue_slot.reg_write = bus.id_reg_write;
            w_issue_slot.is_load   = bus.id_mem_read;
        end
    end

    // Multiply FSM: enter MUL_BUSY on an issuing MUL, leave when count hits 1.
    always_comb begin
        w_state_nxt   = r_state;
        w_mul_cnt_nxt = r_mul_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_issue && bus.id_is_mul && c_MUL_MULTI) begin
                    w_state_nxt   = ST_MUL_BUSY;
                    w_mul_cnt_nxt = c_MUL_LOAD;
                end
            end
            ST_MUL_BUSY: begin
                w_mul_cnt_nxt = r_mul_cnt - 4'd1;
                if (r_mul_cnt == 4'd1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt   = ST_RUN;
                w_mul_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state and multiply countdown registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_mul_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mul_cnt <= w_mul_cnt_nxt;
        end
    end

    // Scoreboard shift; during MUL_BUSY the MUL stays in EX and MEM gets bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (r_state == ST_MUL_BUSY) begin
            r_mem <= '0;
            r_wb  <= r_mem;
        end else begin
            r_ex  <= w_issue_slot;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    // One-cycle flush after each sampled taken branch; re-arms back-to-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush <= 1'b0;
        end else begin
            r_flush <= bus.ex_branch_taken;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    // Retired WB and (in forwarding builds) MEM contents are kept for
    // visibility but do not feed any decision.
    assign w_unused = ^{r_wb, r_mem, r_ex.is_load};

    assign bus.stall_flag   = w_stall;
    assign bus.flush        = r_flush;
    assign bus.mul_busy     = (r_state == ST_MUL_BUSY);
    assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
